// File: rtl/debug_dump_reader_if.sv
// rtl/debug_dump_reader_if.sv - dump frame word stream (valid/ready with last marker)
interface debug_dump_reader_if;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/debug_dump_reader.sv
// rtl/debug_dump_reader.sv - walks CPU debug read ports and streams a header/PC/inst/RF/memory frame
module debug_dump_reader #(
    parameter int unsigned MEM_WORDS = 32,
    parameter logic [31:0] MEM_BASE  = 32'd0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       start,
    output logic [4:0]                 rf_addr,
    output logic [31:0]                mem_addr,
    input  logic [31:0]                rf_data,
    input  logic [31:0]                mem_data,
    input  logic [31:0]                cpu_pc,
    input  logic [31:0]                cpu_inst,
    debug_dump_reader_if.master        out_if,
    output logic                       busy,
    output logic                       done
);
    localparam int unsigned N     = 35 + MEM_WORDS;
    localparam int unsigned IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] RF_FIRST  = IDX_W'(3);
    localparam logic [IDX_W-1:0] MEM_FIRST = IDX_W'(35);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      pc_snap_q;
    logic [31:0]      inst_snap_q;
    logic [15:0]      frame_cnt_q;
    logic [4:0]       rf_addr_q;
    logic [31:0]      mem_addr_q;
    logic             out_valid_q;
    logic [31:0]      out_data_q;
    logic             out_last_q;
    logic             busy_q;
    logic             done_q;
    logic [31:0]      out_data_d;

    // Word source for the current index; the debug addresses were settled on the previous handshake.
    always_comb begin
        out_data_d = mem_data;
        if (idx_q == '0) begin
            out_data_d = {16'hD0D0, frame_cnt_q};
        end else if (idx_q == IDX_W'(1)) begin
            out_data_d = pc_snap_q;
        end else if (idx_q == IDX_W'(2)) begin
            out_data_d = inst_snap_q;
        end else if (idx_q < MEM_FIRST) begin
            out_data_d = rf_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pc_snap_q   <= 32'd0;
            inst_snap_q <= 32'd0;
            frame_cnt_q <= 16'd0;
            rf_addr_q   <= 5'd0;
            mem_addr_q  <= MEM_BASE;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pc_snap_q   <= cpu_pc;
                        inst_snap_q <= cpu_inst;
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= FETCH;
                    end
                end
                FETCH: begin
                    out_data_q  <= out_data_d;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (idx_q == LAST_IDX);
                    state_q     <= SEND;
                end
                SEND: begin
                    if (out_valid_q && out_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            // done rises and busy falls on the final handshake edge itself
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= FIN;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                            if (idx_q >= RF_FIRST && idx_q < MEM_FIRST) begin
                                rf_addr_q <= rf_addr_q + 5'd1;
                            end else if (idx_q >= MEM_FIRST) begin
                                mem_addr_q <= mem_addr_q + 32'd4;
                            end
                            state_q <= FETCH;
                        end
                    end
                end
                FIN: begin
                    done_q      <= 1'b0;
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                    rf_addr_q   <= 5'd0;
                    mem_addr_q  <= MEM_BASE;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rf_addr          = rf_addr_q;
    assign mem_addr         = mem_addr_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_last  = out_last_q;
    assign busy             = busy_q;
    assign done             = done_q;
endmodule

// File: tb/tb_debug_dump_reader.sv
// tb/tb_debug_dump_reader.sv - randomized frame checks of debug_dump_reader against a frame model
module tb_debug_dump_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        start;
    logic        out_ready;
    logic        sel;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_inst;
    logic [31:0] rf    [32];
    logic [31:0] mem_a [32];

    logic [4:0]  rf_addr_a, rf_addr_b;
    logic [31:0] mem_addr_a, mem_addr_b;
    logic [31:0] rf_data_a, rf_data_b, mem_data_a, mem_data_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic        start_a, start_b;

    debug_dump_reader_if ifa ();
    debug_dump_reader_if ifb ();

    function automatic logic [31:0] mem_b_fn(input logic [31:0] a);
        return a ^ 32'h5EED_0000;
    endfunction

    assign start_a       = start & ~sel;
    assign start_b       = start & sel;
    assign ifa.out_ready = out_ready;
    assign ifb.out_ready = out_ready;
    assign rf_data_a     = rf[rf_addr_a];
    assign rf_data_b     = rf[rf_addr_b];
    assign mem_data_a    = mem_a[mem_addr_a[6:2]];
    assign mem_data_b    = mem_b_fn(mem_addr_b);

    debug_dump_reader #(.MEM_WORDS(32), .MEM_BASE(32'd0)) dut_a (
        .clk(clk), .resetn(resetn), .start(start_a),
        .rf_addr(rf_addr_a), .mem_addr(mem_addr_a),
        .rf_data(rf_data_a), .mem_data(mem_data_a),
        .cpu_pc(cpu_pc), .cpu_inst(cpu_inst),
        .out_if(ifa), .busy(busy_a), .done(done_a)
    );

    debug_dump_reader #(.MEM_WORDS(4), .MEM_BASE(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .resetn(resetn), .start(start_b),
        .rf_addr(rf_addr_b), .mem_addr(mem_addr_b),
        .rf_data(rf_data_b), .mem_data(mem_data_b),
        .cpu_pc(cpu_pc), .cpu_inst(cpu_inst),
        .out_if(ifb), .busy(busy_b), .done(done_b)
    );

    logic        obs_valid, obs_last, obs_busy, obs_done;
    logic [31:0] obs_data, obs_mem_addr;
    logic [4:0]  obs_rf_addr;
    assign obs_valid    = sel ? ifb.out_valid : ifa.out_valid;
    assign obs_last     = sel ? ifb.out_last  : ifa.out_last;
    assign obs_data     = sel ? ifb.out_data  : ifa.out_data;
    assign obs_busy     = sel ? busy_b : busy_a;
    assign obs_done     = sel ? done_b : done_a;
    assign obs_rf_addr  = sel ? rf_addr_b : rf_addr_a;
    assign obs_mem_addr = sel ? mem_addr_b : mem_addr_a;

    int n_cmp = 0;
    int n_err = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] exp_q [$];
    logic [31:0] got_d [$];
    logic        got_l [$];
    logic [15:0] cnt_model [2];

    // Reference frame: header, snapshot, all 32 registers, then the memory window.
    function automatic void build_exp(input logic use_b, input logic [15:0] cnt,
                                      input logic [31:0] pc, input logic [31:0] inst);
        int          nw;
        logic [31:0] base, a;
        exp_q.delete();
        exp_q.push_back({16'hD0D0, cnt});
        exp_q.push_back(pc);
        exp_q.push_back(inst);
        for (int r = 0; r < 32; r++) exp_q.push_back(rf[r]);
        nw   = use_b ? 4 : 32;
        base = use_b ? 32'hFFFF_FFF8 : 32'd0;
        for (int i = 0; i < nw; i++) begin
            a = base + 32'(4 * i);
            exp_q.push_back(use_b ? mem_b_fn(a) : mem_a[a[6:2]]);
        end
    endfunction

    task automatic run_frame(input int ready_pct, input bit pulses, input int abort_words);
        logic [31:0] pc0, inst0, pd, base;
        logic        pl;
        bit          fin, stall, seen_last;
        int          cyc, last_cyc, nwords, early_done;
        got_d.delete();
        got_l.delete();
        nwords = sel ? 39 : 67;
        base   = sel ? 32'hFFFF_FFF8 : 32'd0;
        pc0    = $urandom;
        inst0  = $urandom;
        @(negedge clk);
        cpu_pc = pc0; cpu_inst = inst0; start = 1'b1; out_ready = 1'b0;
        build_exp(sel, cnt_model[sel], pc0, inst0);
        @(negedge clk);
        start = 1'b0; cpu_pc = $urandom; cpu_inst = $urandom;
        #1;
        expect_eq("start_busy", obs_busy, 1);
        expect_eq("start_novalid", obs_valid, 0);
        cyc = 0; fin = 0; stall = 0; seen_last = 0; last_cyc = -1; early_done = 0;
        pd = '0; pl = 0;
        while (!fin && cyc < 30 * nwords) begin
            @(negedge clk);
            out_ready = ($urandom_range(99) < ready_pct);
            start     = pulses && (cyc % 5 == 0);
            #1;
            if (cyc == 0) expect_eq("hdr_latency", obs_valid, 1);
            if (obs_done) early_done++;
            if (stall) begin
                expect_eq("hold_valid", obs_valid, 1);
                expect_eq("hold_data", obs_data, pd);
                expect_eq("hold_last", obs_last, pl);
            end
            stall = obs_valid && !out_ready;
            pd    = obs_data;
            pl    = obs_last;
            if (obs_valid && out_ready) begin
                got_d.push_back(obs_data);
                got_l.push_back(obs_last);
                if (abort_words > 0 && got_d.size() == abort_words) fin = 1;
                if (obs_last) begin
                    fin = 1; seen_last = 1; last_cyc = cyc;
                end
            end
            cyc++;
        end
        start = 1'b0;
        if (abort_words > 0) return;
        expect_eq("frame_complete", seen_last, 1);
        expect_eq("no_early_done", early_done, 0);
        if (ready_pct == 100) expect_eq("throughput", last_cyc, 2 * nwords - 2);
        @(negedge clk); #1;
        expect_eq("done_pulse", obs_done, 1);
        expect_eq("busy_fall", obs_busy, 0);
        @(negedge clk); #1;
        expect_eq("done_single", obs_done, 0);
        expect_eq("rf_addr_restore", obs_rf_addr, 0);
        expect_eq("mem_addr_restore", obs_mem_addr, base);
        expect_eq("nwords", got_d.size(), nwords);
        for (int i = 0; i < nwords && i < got_d.size(); i++) begin
            expect_eq($sformatf("word%0d", i), got_d[i], exp_q[i]);
            expect_eq($sformatf("last%0d", i), got_l[i], (i == nwords - 1));
        end
        cnt_model[sel] = cnt_model[sel] + 16'd1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int act;
        resetn = 1'b0; start = 1'b0; out_ready = 1'b0; sel = 1'b0;
        cpu_pc = '0; cpu_inst = '0;
        cnt_model[0] = '0; cnt_model[1] = '0;
        for (int r = 0; r < 32; r++) begin
            rf[r]    = $urandom;
            mem_a[r] = $urandom;
        end
        rf[5]    = 32'h1234_5678;
        mem_a[2] = 32'hCAFE_BABE;

        repeat (3) @(negedge clk);
        #1;
        expect_eq("rst_valid", ifa.out_valid, 0);
        expect_eq("rst_data", ifa.out_data, 0);
        expect_eq("rst_last", ifa.out_last, 0);
        expect_eq("rst_busy", busy_a, 0);
        expect_eq("rst_done", done_a, 0);
        expect_eq("rst_rf_addr", rf_addr_a, 0);
        expect_eq("rst_mem_addr_b", mem_addr_b, 32'hFFFF_FFF8);
        resetn = 1'b1;
        act = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            out_ready = $urandom_range(1);
            #1;
            if (busy_a || done_a || ifa.out_valid || rf_addr_a != 0 || mem_addr_a != 0 ||
                busy_b || ifb.out_valid) act++;
        end
        expect_eq("idle_quiet", act, 0);

        run_frame(100, 0, -1);
        if (got_d.size() >= 67) begin
            expect_eq("hdr0", got_d[0], 32'hD0D0_0000);
            expect_eq("r5_word8", got_d[8], 32'h1234_5678);
            expect_eq("mem8_word37", got_d[37], 32'hCAFE_BABE);
        end

        run_frame(30, 0, -1);
        run_frame(100, 1, -1);
        run_frame(60, 0, -1);
        if (got_d.size() > 0) expect_eq("hdr_cnt3", got_d[0], 32'hD0D0_0003);

        run_frame(100, 0, 21);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        expect_eq("arst_valid", ifa.out_valid, 0);
        expect_eq("arst_data", ifa.out_data, 0);
        expect_eq("arst_last", ifa.out_last, 0);
        expect_eq("arst_busy", busy_a, 0);
        expect_eq("arst_done", done_a, 0);
        expect_eq("arst_rf_addr", rf_addr_a, 0);
        expect_eq("arst_mem_addr", mem_addr_a, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        cnt_model[0] = '0; cnt_model[1] = '0;
        run_frame(100, 0, -1);
        if (got_d.size() > 0) expect_eq("hdr_after_rst", got_d[0], 32'hD0D0_0000);

        sel = 1'b1;
        run_frame(100, 0, -1);
        run_frame(40, 1, -1);
        if (got_d.size() >= 39) begin
            expect_eq("wrap_w35", got_d[35], mem_b_fn(32'hFFFF_FFF8));
            expect_eq("wrap_w36", got_d[36], mem_b_fn(32'hFFFF_FFFC));
            expect_eq("wrap_w37", got_d[37], mem_b_fn(32'h0000_0000));
            expect_eq("wrap_w38", got_d[38], mem_b_fn(32'h0000_0004));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
